ram_banked: RTL and testbench
=============================

Name: ram_banked

Overview:
- Next-generation parametrised scratchpad for the accelerator datapath.
- Storage is split into BANKS word-interleaved single-port banks, each DEPTH/BANKS rows deep.
- Provides:
  - one write port with per-lane byte masks;
  - one read port with a registered 1-cycle read and a ready/valid handshake;
  - a hardware clear engine that replaces reset-time array clearing. The clear runs automatically after reset and can also be started on request.

Parameters:
- WIDTH, 264, data word width in bits.
- LANES, 33, number of write-mask lanes. Lane width LW = WIDTH/LANES (8 by default). WIDTH % LANES must be 0.
- DEPTH, 2048, total words. DEPTH % BANKS must be 0.
- BANKS, 4, number of banks. Must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), address width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clr  in  1  1-cycle pulse that starts a full clear.
- o_busy  out  1  clear in progress.
- i_wr_en  in  1  write request.
- i_wr_addr  in  ADDR_W  write word address.
- i_wr_mask  in  LANES  lane enables; bit k covers data bits [k*LW +: LW].
- i_wr_data  in  WIDTH  write data.
- i_rd_en  in  1  read request.
- o_rd_ready  out  1  read request accepted this cycle.
- i_rd_addr  in  ADDR_W  read word address.
- o_rd_valid  out  1  read data valid (1-cycle pulse).
- o_rd_data  out  WIDTH  read data; holds its value until the next valid.

Behaviour:
- Address map:
  - bank = addr[BW-1:0], where BW = log2(BANKS);
  - row = addr[ADDR_W-1:BW].
- Reset (asynchronous, active-low):
  - o_rd_valid=0, o_rd_data=0, o_busy=1, o_rd_ready=0, clear row counter=0, FSM=CLEAR.
  - Array contents are NOT reset by i_rst_n; the clear engine zeroes them.
- FSM states: CLEAR, IDLE.
  - CLEAR: every cycle, all banks write zero at the current row counter (all lanes). The counter increments each cycle. When row = DEPTH/BANKS-1 is written, go to IDLE, o_busy drops to 0 on the following cycle. A clear takes exactly DEPTH/BANKS cycles (512 by default).
  - IDLE: o_busy=0. An i_clr pulse moves the FSM to CLEAR with row counter 0 on the next edge.
  - i_clr while in CLEAR is ignored (no restart).
  - Reset mid-clear restarts the clear from row 0.
- While o_busy=1:
  - i_wr_en is dropped (no effect);
  - o_rd_ready=0;
  - o_rd_valid=0.
- Write:
  - In IDLE, i_wr_en writes the masked lanes of i_wr_data into bank/row at the clock edge. Unmasked lanes keep their old value.
  - i_wr_mask = 0 is a legal no-op.
  - Writes are always accepted; the port has no stall.
- Read:
  - o_rd_ready is combinational: 1 when IDLE and NOT (i_wr_en AND same bank as the write).
  - An accepted read (i_rd_en AND o_rd_ready) at edge N yields o_rd_valid=1 and the data in the cycle after edge N (latency 1).
  - A bank conflict stalls the read; the write wins. The requester holds i_rd_en and i_rd_addr until o_rd_ready=1.
  - A stalled read at the same address as the write returns the newly written data when it issues.
  - A write and a read to different banks in the same cycle both proceed.
  - Back-to-back reads sustain 1 word/cycle.
- Width rules:
  - o_rd_data is the full WIDTH word; no truncation or extension.
  - Address upper bits beyond ADDR_W do not exist; every address in 0..DEPTH-1 is valid.

Decomposition:
- Shared package holds:
  - LW, BW and row-width derivations as constants;
  - FSM state encoding (CLEAR, IDLE);
  - the ADDR_W default shared with the rest of the buffer hierarchy.
- Sub-module ram_bank:
  - single-port, ROWS deep, WIDTH wide;
  - inputs: en, we, lane mask, row, data;
  - registered read output.
  - Instantiated BANKS times via generate. The top level owns bank select, conflict arbitration, the clear FSM and output muxing. The output mux uses the bank index registered one cycle.

Test Plan:
1. Release reset, idle inputs -> o_busy=1 for exactly 512 cycles then 0; reads of addresses 0, 5, 2047 return 0 with o_rd_valid one cycle after acceptance.
2. Write addr 10, mask all-ones, data 0xAB repeated; then write addr 10, mask lane 0 only, data 0x...CD -> read returns 0xAB in lanes 1..32 and 0xCD in lane 0.
3. Same cycle: write addr 4 (bank 0), read addr 8 (bank 0) -> o_rd_ready=0 that cycle; next cycle ready=1 and the read of addr 8 proceeds. Then write addr 4 with read addr 5 (bank 1) -> ready=1, both proceed.
4. Write addr 7 = 0x55.., then in the same cycle write addr 7 = 0x66.. while reading addr 7 -> read stalls one cycle, then returns 0x66..
5. Fill addresses 0..15 with nonzero data, pulse i_clr; pulse i_clr again mid-clear -> o_busy high 512 cycles from the first pulse only; writes and reads are blocked during clear; afterwards all 16 addresses read 0.
6. Assert i_rst_n low at clear row 200 -> o_busy stays 1; after release the clear runs a full 512 cycles from row 0; o_rd_data is 0 while reset is asserted.

Source files
------------

// File: rtl/ram_banked_pkg.sv
// Shared constants, derivations and FSM encoding for the banked scratchpad.
// Imported by ram_bank and ram_banked.
package ram_banked_pkg;

    localparam int WIDTH_DEF  = 264;
    localparam int LANES_DEF  = 33;
    localparam int DEPTH_DEF  = 2048;
    localparam int BANKS_DEF  = 4;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int lane_w(int width, int lanes);
        return width / lanes;
    endfunction

    function automatic int bank_w(int banks);
        return $clog2(banks);
    endfunction

    function automatic int row_w(int depth, int banks);
        return $clog2(depth / banks);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Single-port storage bank with per-lane write mask and registered read.
// Ports: clk, rst_n, en, we, mask[LANES], row[RW], data[WIDTH], q[WIDTH].
module ram_bank
    import ram_banked_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF,
    parameter int ROWS  = DEPTH_DEF / BANKS_DEF,
    parameter int RW    = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [LANES-1:0] mask,
    input  logic [RW-1:0]    row,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    localparam int LW = lane_w(WIDTH, LANES);

    logic [WIDTH-1:0] mem [ROWS];

    // Array contents are deliberately not reset; the clear engine zeroes them.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < LANES; k++) begin
                if (mask[k]) begin
                    mem[row][k*LW +: LW] <= data[k*LW +: LW];
                end
            end
        end
    end

    // Read register only updates on a read, so q holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && !we) begin
            q <= mem[row];
        end
    end

endmodule

// File: rtl/ram_banked.sv
// Word-interleaved banked scratchpad with masked write port, 1-cycle read
// port with ready/valid, and a clear engine that zeroes the array.
// Ports: i_clk, i_rst_n, i_clr, o_busy, write (i_wr_en/addr/mask/data),
// read request (i_rd_en, i_rd_addr, o_rd_ready), read result (o_rd_valid,
// o_rd_data).
module ram_banked
    import ram_banked_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BANKS  = BANKS_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    output logic              o_busy,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [LANES-1:0]  i_wr_mask,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_valid,
    output logic [WIDTH-1:0]  o_rd_data
);

    localparam int BW   = bank_w(BANKS);
    localparam int ROWS = DEPTH / BANKS;
    localparam int RW   = row_w(DEPTH, BANKS);

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_nxt;

    logic          busy;
    logic [BW-1:0] wr_bank;
    logic [BW-1:0] rd_bank;
    logic [RW-1:0] wr_row;
    logic [RW-1:0] rd_row;
    logic          wr_go;
    logic          rd_go;
    logic          conflict;

    logic [LANES-1:0] bk_mask;
    logic [WIDTH-1:0] bk_data;
    logic [WIDTH-1:0] bk_q [BANKS];

    logic          valid_q;
    logic [BW-1:0] rd_bank_q;

    assign busy    = (state == ST_CLEAR);
    assign o_busy  = busy;

    assign wr_bank = i_wr_addr[BW-1:0];
    assign rd_bank = i_rd_addr[BW-1:0];
    assign wr_row  = i_wr_addr[ADDR_W-1:BW];
    assign rd_row  = i_rd_addr[ADDR_W-1:BW];

    // Writes never stall; a read to the bank being written waits a cycle.
    assign wr_go      = i_wr_en && !busy;
    assign conflict   = wr_go && (wr_bank == rd_bank);
    assign o_rd_ready = !busy && !conflict;
    assign rd_go      = i_rd_en && o_rd_ready;

    // Clear forces all lanes to zero in every bank.
    assign bk_mask = busy ? '1 : i_wr_mask;
    assign bk_data = busy ? '0 : i_wr_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_CLEAR;
            row_q <= '0;
        end else begin
            state <= state_nxt;
            row_q <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_q;
        unique case (state)
            ST_CLEAR: begin
                row_nxt = row_q + 1'b1;
                if (row_q == RW'(ROWS - 1)) begin
                    state_nxt = ST_IDLE;
                    row_nxt   = '0;
                end
            end
            ST_IDLE: begin
                if (i_clr) begin
                    state_nxt = ST_CLEAR;
                    row_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                row_nxt   = '0;
            end
        endcase
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic          wr_sel;
        logic          rd_sel;
        logic          en;
        logic          we;
        logic [RW-1:0] row;

        assign wr_sel = wr_go && (wr_bank == BW'(b));
        assign rd_sel = rd_go && (rd_bank == BW'(b));
        assign en     = busy || wr_sel || rd_sel;
        assign we     = busy || wr_sel;

        always_comb begin
            row = rd_row;
            if (busy) begin
                row = row_q;
            end else if (wr_sel) begin
                row = wr_row;
            end
        end

        ram_bank #(
            .WIDTH (WIDTH),
            .LANES (LANES),
            .ROWS  (ROWS),
            .RW    (RW)
        ) u_bank (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .en    (en),
            .we    (we),
            .mask  (bk_mask),
            .row   (row),
            .data  (bk_data),
            .q     (bk_q[b])
        );
    end

    // Bank index is registered alongside the read so the mux lines up
    // with the bank's registered output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            valid_q <= rd_go;
            if (rd_go) begin
                rd_bank_q <= rd_bank;
            end
        end
    end

    // A read accepted on the same edge as a clear request is squashed.
    assign o_rd_valid = valid_q && !busy;
    assign o_rd_data  = bk_q[rd_bank_q];

endmodule

// File: tb/tb_ram_banked.sv
// Randomised and directed bench for ram_banked against a word-array model.
// Reports per-comparison failures and one summary line.
module tb_ram_banked;

    localparam int W    = 264;
    localparam int L    = 33;
    localparam int D    = 2048;
    localparam int B    = 4;
    localparam int AW   = 11;
    localparam int ROWS = D / B;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [L-1:0]  wr_mask;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [W-1:0]  rd_data;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mdl [D];
    int           busy_left;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         last_acc;

    ram_banked dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clr      (clr),
        .o_busy     (busy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_mask  (wr_mask),
        .i_wr_data  (wr_data),
        .i_rd_en    (rd_en),
        .o_rd_ready (rd_ready),
        .i_rd_addr  (rd_addr),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 8; i++) begin
            w[i*8 +: 8] = 8'($urandom_range(1, 255));
        end
        return w;
    endfunction

    function automatic logic [W-1:0] merge(logic [W-1:0] old,
                                           logic [W-1:0] nw,
                                           logic [L-1:0] m);
        logic [W-1:0] r;
        r = old;
        for (int k = 0; k < L; k++) begin
            if (m[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) mdl[i] = '0;
        busy_left = ROWS;
        exp_valid = 1'b0;
        exp_data  = '0;
    endtask

    task automatic idle();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // One clock: inputs already driven at the negedge.
    task automatic step();
        logic exp_rdy;
        #1;
        exp_rdy = (busy_left == 0) &&
                  !(wr_en && ((int'(wr_addr) % B) == (int'(rd_addr) % B)));
        chk("ready", W'(rd_ready), W'(exp_rdy));
        @(posedge clk);
        last_acc = 1'b0;
        if (busy_left > 0) begin
            busy_left--;
            exp_valid = 1'b0;
        end else begin
            exp_valid = rd_en && exp_rdy;
            last_acc  = exp_valid;
            if (exp_valid) exp_data = mdl[rd_addr];
            if (wr_en) mdl[wr_addr] = merge(mdl[wr_addr], wr_data, wr_mask);
            if (clr) begin
                busy_left = ROWS;
                exp_valid = 1'b0;
                for (int i = 0; i < D; i++) mdl[i] = '0;
            end
        end
        @(negedge clk);
        chk("busy", W'(busy), W'(busy_left > 0));
        chk("valid", W'(rd_valid), W'(exp_valid));
        chk("data", rd_data, exp_data);
    endtask

    task automatic do_write(int a, logic [L-1:0] m, logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_mask = m; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        step();
        rd_en = 1'b0;
        step();
    endtask

    task automatic wait_clear();
        for (int i = 0; i < ROWS + 2; i++) step();
    endtask

    initial begin
        logic [W-1:0] w;
        rst_n = 1'b0;
        idle();
        wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
        model_reset();
        @(negedge clk);
        chk("rst_busy", W'(busy), W'(1'b1));
        chk("rst_valid", W'(rd_valid), W'(1'b0));
        chk("rst_data", rd_data, '0);
        chk("rst_ready", W'(rd_ready), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Initial clear, then reads of cleared words.
        wait_clear();
        do_read(0);
        do_read(5);
        do_read(D - 1);

        // Full write then single-lane overwrite.
        do_write(10, '1, {33{8'hAB}});
        w = rnd_word();
        w[7:0] = 8'hCD;
        do_write(10, L'(1), w);
        do_read(10);
        chk("lane_merge", mdl[10], {{32{8'hAB}}, 8'hCD});

        // Same-bank conflict, then different-bank parallel access.
        wr_en = 1'b1; wr_addr = 4; wr_mask = '1; wr_data = rnd_word();
        rd_en = 1'b1; rd_addr = 8;
        step();
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = 4; wr_data = rnd_word();
        rd_en = 1'b1; rd_addr = 5;
        step();
        idle();
        step();

        // Stalled read returns the word written in the blocking cycle.
        do_write(7, '1, {33{8'h55}});
        wr_en = 1'b1; wr_addr = 7; wr_mask = '1; wr_data = {33{8'h66}};
        rd_en = 1'b1; rd_addr = 7;
        step();
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        step();
        chk("stall_data", rd_data, {33{8'h66}});

        // Fill, clear, ignored second clear, traffic blocked while busy.
        for (int a = 0; a < 16; a++) do_write(a, '1, rnd_word());
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < ROWS + 2; i++) begin
            clr   = (i == 100);
            wr_en = 1'(i % 3 == 0);
            wr_addr = AW'($urandom_range(0, 15));
            wr_mask = '1;
            wr_data = rnd_word();
            rd_en = 1'(i % 2 == 0);
            rd_addr = AW'($urandom_range(0, 15));
            step();
        end
        idle();
        for (int a = 0; a < 16; a++) do_read(a);

        // Nonzero data on the output, then reset in the middle of a clear.
        do_write(3, '1, rnd_word());
        do_read(3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 200; i++) step();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_rst_busy", W'(busy), W'(1'b1));
            chk("mid_rst_data", rd_data, '0);
            chk("mid_rst_valid", W'(rd_valid), W'(1'b0));
            @(negedge clk);
        end
        rst_n = 1'b1;
        wait_clear();

        // Random traffic; a stalled read holds its address.
        for (int i = 0; i < 3000; i++) begin
            logic hold;
            hold  = rd_en && !last_acc;
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 1) != 0) ?
                      AW'($urandom_range(0, 31)) : AW'($urandom);
            wr_mask = {$urandom, $urandom_range(0, 1) != 0};
            wr_data = rnd_word();
            if (!hold) begin
                rd_en = 1'($urandom_range(0, 3) != 0);
                rd_addr = ($urandom_range(0, 1) != 0) ?
                          AW'($urandom_range(0, 31)) : AW'($urandom);
            end
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
